lane_obstacle_hit: RTL
======================

Name: lane_obstacle_hit

Overview:
- Consumer of a scroller's horizontal position output, one instance per obstacle lane.
- Latches the obstacle x position once per frame and renders the obstacle into the VGA pixel stream, wrapping at the 640-pixel screen edge.
- Detects overlap with the player sprite. Runs a small collision FSM that emits a single hit pulse, then holds off during a cooldown.
- Sits between the scroller/player logic and the top-level colour mux and game-state logic.

Parameters:
- SCREEN_WIDTH, 640, horizontal wrap modulus for obstacle position.
- OBJ_W, 32, obstacle width in pixels.
- OBJ_H, 16, obstacle height in pixels.
- PLAYER_W, 16, player sprite width and height in pixels.
- HIT_FRAMES, 2, consecutive overlapping frames required to declare a hit.
- COOL_FRAMES, 30, frames ignored after a hit.

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- h_pos  in  10  obstacle left x, 0..SCREEN_WIDTH-1, from the scroller.
- lane_y  in  10  obstacle top y; static per lane.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- video_active  in  1  high during visible pixels.
- frame_start  in  1  one-cycle pulse per frame; occurs during blanking.
- player_x  in  10  player left x.
- player_y  in  10  player top y.
- obs_pix  out  1  obstacle covers the current pixel; registered.
- hit_pulse  out  1  one-cycle collision event.
- hit_count  out  4  saturating count of hits.
- busy  out  1  high while in state HIT or COOLDOWN.

Behaviour:
- Reset (async, rst_n=0):
  - h_lat=0, obs_pix=0, hit_pulse=0, hit_count=0, busy=0.
  - overlap_seen=0, frame and consecutive counters=0, state=CLEAR.
- Position latch:
  - h_lat<=h_pos on each frame_start cycle only.
  - Changes to h_pos mid-frame have no effect on rendering until the next frame_start.
  - An out-of-range h_pos (>=SCREEN_WIDTH) is latched as 0.
- Horizontal coverage, computed in 11 bits:
  - dx = pix_x - h_lat; if negative, dx += SCREEN_WIDTH.
  - in_x = (dx < OBJ_W).
  - Consequence: an obstacle with h_lat=620 covers x 620..639 and 0..11.
- Vertical coverage: in_y = (pix_y >= lane_y) && (pix_y < lane_y + OBJ_H), compared in 11 bits with no wrap.
- obs_pix: registered; equals video_active && in_x && in_y of the previous cycle (latency 1 clock).
- Player coverage: in_p = pix_x in [player_x, player_x+PLAYER_W) && pix_y in [player_y, player_y+PLAYER_W), unregistered.
- Overlap tracking:
  - overlap_seen is set on any cycle with video_active && in_x && in_y && in_p.
  - overlap_seen is cleared on frame_start, after that cycle's evaluation.
  - An overlap on the frame_start cycle itself (video_active=1) is attributed to the closing frame.
- FSM, advanced only on frame_start cycles:
  - CLEAR:
    - overlap_seen=1 -> cons=1. If HIT_FRAMES==1, go to HIT; otherwise go to ARMED.
    - overlap_seen=0 -> stay in CLEAR.
  - ARMED:
    - overlap_seen=1 -> cons+1. When cons reaches HIT_FRAMES, go to HIT.
    - overlap_seen=0 -> cons=0, go to CLEAR.
  - HIT:
    - Entry is registered. hit_pulse is high for exactly the one clk after the transitioning frame_start.
    - hit_count increments, saturating at 15.
    - HIT advances to COOLDOWN on that next clk, not on a frame_start; cool=0.
  - COOLDOWN:
    - Each frame_start does cool+1; overlaps are ignored.
    - When cool==COOL_FRAMES-1, go to CLEAR with cons=0.
- Reset mid-operation: all state returns to reset values immediately. No pending pulse survives reset.
- busy = (state==HIT || state==COOLDOWN).

Optional Feature:
- Macro: LANE_CORNER_MASK_EN.
- Defined: the 2x2 pixel square at each of the obstacle's four corners (local dx<2 or dx>=OBJ_W-2, combined with dy<2 or dy>=OBJ_H-2) is excluded from both obs_pix and overlap detection.
- Not defined: the full OBJ_W x OBJ_H rectangle is solid.
- Ports and latency are identical in both cases.

Decomposition:
- Shared package lane_pkg holds:
  - SCREEN_WIDTH and SCREEN_HEIGHT constants.
  - Coordinate width (10).
  - FSM state enum: CLEAR, ARMED, HIT, COOLDOWN.
- Sub-module wrap_span_cmp: combinational in_x computation (position, span width, modulus). It is reused by the player/obstacle render path.

Test Plan:
- Wrap render: h_pos=620 latched, lane_y=100, pix_y=105 -> obs_pix=1 one clk after pix_x=625 and after pix_x=5; obs_pix=0 at pix_x=12 and pix_x=619.
- Mid-frame change: h_pos 100->300 between frame_starts -> rendering stays at 100..131 until the next frame_start, then moves to 300..331.
- Two-frame hit:
  - Setup: player at (110,100) overlapping the obstacle for 2 consecutive frames.
  - Required: hit_pulse exactly 1 clk after the second frame_start; hit_count=1; busy=1.
- Single-frame graze: overlap in 1 frame, none in the next -> no hit_pulse; state returns to CLEAR; hit_count=0.
- Cooldown: continuous overlap for 40 frames -> exactly 2 hit_pulses (frames 2 and 34); busy low in frames 32..33.
- Async reset: assert rst_n=0 while in COOLDOWN with hit_count=3 -> outputs clear immediately without a clk edge; after release, the FSM is in CLEAR.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared constants and types for the obstacle lane logic.
package lane_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int COORD_W       = 10;

    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        ARMED    = 2'd1,
        HIT      = 2'd2,
        COOLDOWN = 2'd3
    } lane_state_t;

endpackage

// File: rtl/wrap_span_cmp.sv
// Horizontal span test with wrap-around at the screen edge.
// Reports whether a pixel column lies inside [pos, pos+SPAN) taken modulo MOD,
// and the local offset of that column from the span's left edge.
module wrap_span_cmp
    import lane_pkg::*;
#(
    parameter int SPAN = 32,
    parameter int MOD  = 640
) (
    input  logic [COORD_W-1:0] pos,
    input  logic [COORD_W-1:0] pix,
    output logic               in_span,
    output logic [COORD_W:0]   dx
);

    localparam logic [COORD_W:0] SPAN_W = (COORD_W+1)'(SPAN);
    localparam logic [COORD_W:0] MOD_W  = (COORD_W+1)'(MOD);

    // Offset from the left edge, folded back into range when the pixel is left of pos.
    always_comb begin
        dx = {1'b0, pix} - {1'b0, pos};
        if (pix < pos) begin
            dx = dx + MOD_W;
        end
        in_span = (dx < SPAN_W);
    end

endmodule

// File: rtl/lane_obstacle_hit.sv
// One obstacle lane: latches the scroller position each frame, renders the
// obstacle into the pixel stream with horizontal wrap, and runs a collision
// FSM that pulses once per hit followed by a cooldown.
// Build option LANE_CORNER_MASK_EN trims a 2x2 square off each obstacle corner
// for both rendering and collision.
module lane_obstacle_hit #(
    parameter int SCREEN_WIDTH = lane_pkg::SCREEN_WIDTH,
    parameter int OBJ_W        = 32,
    parameter int OBJ_H        = 16,
    parameter int PLAYER_W     = 16,
    parameter int HIT_FRAMES   = 2,
    parameter int COOL_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_pos,
    input  logic [9:0] lane_y,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_active,
    input  logic       frame_start,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       obs_pix,
    output logic       hit_pulse,
    output logic [3:0] hit_count,
    output logic       busy
);

    import lane_pkg::*;

    localparam logic [10:0] OBJ_W_W    = 11'(OBJ_W);
    localparam logic [10:0] OBJ_H_W    = 11'(OBJ_H);
    localparam logic [10:0] PLAYER_W_W = 11'(PLAYER_W);
    localparam logic [10:0] SCREEN_W_W = 11'(SCREEN_WIDTH);
    localparam logic [7:0]  HIT_N      = 8'(HIT_FRAMES);
    localparam logic [7:0]  COOL_LAST  = 8'(COOL_FRAMES - 1);
`ifdef LANE_CORNER_MASK_EN
    localparam bit CORNER_MASK = 1'b1;
`else
    localparam bit CORNER_MASK = 1'b0;
`endif

    logic [9:0]  h_lat;
    logic        in_x;
    logic [10:0] dx;
    logic [10:0] py11;
    logic [10:0] ly11;
    logic [10:0] dy;
    logic        in_y;
    logic        corner;
    logic        obj_here;
    logic        in_p;
    logic        overlap_now;
    logic        overlap_seen;
    logic        overlap_frame;

    lane_state_t state;
    lane_state_t state_next;
    logic [7:0]  cons;
    logic [7:0]  cons_next;
    logic [7:0]  cool;
    logic [7:0]  cool_next;
    logic [3:0]  count_next;

    wrap_span_cmp #(
        .SPAN(OBJ_W),
        .MOD (SCREEN_WIDTH)
    ) u_span (
        .pos    (h_lat),
        .pix    (pix_x),
        .in_span(in_x),
        .dx     (dx)
    );

    assign py11 = {1'b0, pix_y};
    assign ly11 = {1'b0, lane_y};
    assign dy   = py11 - ly11;
    assign in_y = (py11 >= ly11) && (py11 < ly11 + OBJ_H_W);

    assign corner   = ((dx < 11'd2) || (dx >= OBJ_W_W - 11'd2)) &&
                      ((dy < 11'd2) || (dy >= OBJ_H_W - 11'd2));
    assign obj_here = in_x && in_y && !(CORNER_MASK && corner);

    assign in_p = ({1'b0, pix_x} >= {1'b0, player_x}) &&
                  ({1'b0, pix_x} <  {1'b0, player_x} + PLAYER_W_W) &&
                  ({1'b0, pix_y} >= {1'b0, player_y}) &&
                  ({1'b0, pix_y} <  {1'b0, player_y} + PLAYER_W_W);

    assign overlap_now   = video_active && obj_here && in_p;
    // An overlap on the frame_start cycle still belongs to the frame being closed.
    assign overlap_frame = overlap_seen || overlap_now;

    // Frame position latch, registered pixel output and per-frame overlap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_lat        <= 10'd0;
            obs_pix      <= 1'b0;
            overlap_seen <= 1'b0;
        end else begin
            obs_pix <= video_active && obj_here;
            if (frame_start) begin
                h_lat        <= ({1'b0, h_pos} >= SCREEN_W_W) ? 10'd0 : h_pos;
                overlap_seen <= 1'b0;
            end else if (overlap_now) begin
                overlap_seen <= 1'b1;
            end
        end
    end

    // Collision FSM state, consecutive/cooldown counters and hit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            cons      <= 8'd0;
            cool      <= 8'd0;
            hit_count <= 4'd0;
        end else begin
            state     <= state_next;
            cons      <= cons_next;
            cool      <= cool_next;
            hit_count <= count_next;
        end
    end

    // Next-state logic: advances on frame_start except HIT, which lasts one clock.
    always_comb begin
        state_next = state;
        cons_next  = cons;
        cool_next  = cool;
        count_next = hit_count;
        case (state)
            CLEAR: begin
                if (frame_start && overlap_frame) begin
                    cons_next = 8'd1;
                    if (HIT_FRAMES == 1) begin
                        state_next = HIT;
                    end else begin
                        state_next = ARMED;
                    end
                end
            end
            ARMED: begin
                if (frame_start) begin
                    if (overlap_frame) begin
                        cons_next = cons + 8'd1;
                        if (cons + 8'd1 >= HIT_N) begin
                            state_next = HIT;
                        end
                    end else begin
                        cons_next  = 8'd0;
                        state_next = CLEAR;
                    end
                end
            end
            HIT: begin
                state_next = COOLDOWN;
                cool_next  = 8'd0;
            end
            COOLDOWN: begin
                if (frame_start) begin
                    if (cool == COOL_LAST) begin
                        state_next = CLEAR;
                        cons_next  = 8'd0;
                    end else begin
                        cool_next = cool + 8'd1;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
        if ((state_next == HIT) && (state != HIT) && (hit_count != 4'hF)) begin
            count_next = hit_count + 4'd1;
        end
    end

    assign hit_pulse = (state == HIT);
    assign busy      = (state == HIT) || (state == COOLDOWN);

endmodule
